// File: rtl/mtimer_if.sv
// Request/response bus between a host and the mtimer register block.
// One request is accepted per req_valid & req_ready; one response is outstanding at most.
interface mtimer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, mtimecmp compare
// interrupt, enable control and a hi-word shadow for tear-free 32-bit reads.
module mtimer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic     clk,
  input  logic     reset,
  mtimer_if.slave  bus,
  output logic     irq_mtimecmp
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [15:0] presc_q, presc_d;
  logic        enable_q, enable_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        irq_q, irq_d;

  logic        req_ready;
  logic        accept;
  logic [2:0]  word;
  logic        mapped;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [31:0] rd_data;
  logic        unused_addr_lsb;

  assign req_ready       = ~resp_valid_q | bus.resp_ready;
  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign irq_mtimecmp    = irq_q;
  assign unused_addr_lsb = ^bus.req_addr[1:0];

  always_comb begin
    accept = bus.req_valid & req_ready;
    word   = bus.req_addr[4:2];
    mapped = (word <= 3'd4);
    wr_en  = accept & bus.req_write & mapped;
    rd_en  = accept & ~bus.req_write;

    // Read mux works on pre-update register values.
    case (word)
      3'd0:    rd_data = mtime_q[31:0];
      3'd1:    rd_data = shadow_q;
      3'd2:    rd_data = mtimecmp_q[31:0];
      3'd3:    rd_data = mtimecmp_q[63:32];
      3'd4:    rd_data = {31'b0, enable_q};
      default: rd_data = 32'b0;
    endcase

    tick    = enable_q & (presc_q == PRESC_MAX);
    presc_d = presc_q;
    if (enable_q) presc_d = tick ? 16'd0 : presc_q + 16'd1;

    // A bus write with any strobe set to an mtime word wins over the tick.
    mtime_d = mtime_q + {63'b0, tick};
    if (wr_en && (bus.req_wstrb != 4'b0)) begin
      if (word == 3'd0)
        mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.req_wdata, bus.req_wstrb)};
      else if (word == 3'd1)
        mtime_d = {merge_bytes(mtime_q[63:32], bus.req_wdata, bus.req_wstrb), mtime_q[31:0]};
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_en && word == 3'd2)
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus.req_wdata, bus.req_wstrb);
    if (wr_en && word == 3'd3)
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.req_wdata, bus.req_wstrb);

    enable_d = enable_q;
    if (wr_en && word == 3'd4 && bus.req_wstrb[0]) enable_d = bus.req_wdata[0];

    shadow_d = shadow_q;
    if (rd_en && word == 3'd0) shadow_d = mtime_q[63:32];

    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = (bus.req_write || !mapped) ? 32'b0 : rd_data;
      resp_err_d   = ~mapped;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end

    irq_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q      <= 64'b0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q     <= 32'b0;
      presc_q      <= 16'b0;
      enable_q     <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      shadow_q     <= shadow_d;
      presc_q      <= presc_d;
      enable_q     <= enable_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 SHALL have parameter: PRESCALE, 1, clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  bus request present.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid & req_ready.
REQ-006 SHALL have port: req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: req_addr  input  5  byte offset; bits [1:0] ignored.
REQ-008 SHALL have port: req_wdata  input  32  write data.
REQ-009 SHALL have port: req_wstrb  input  4  byte enables for writes.
REQ-010 SHALL have port: resp_valid  output  1  response present.
REQ-011 SHALL have port: resp_ready  input  1  response consumed when resp_valid & resp_ready.
REQ-012 SHALL have port: resp_rdata  output  32  read data; 0 for writes.
REQ-013 SHALL have port: resp_err  output  1  unmapped address.
REQ-014 SHALL have port: irq_mtimecmp  output  1  machine timer interrupt level to the CSR/exception unit.

Function
REQ-015 SHALL map word offsets: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 ctrl (bit0 = enable, bits[31:1] read 0); 0x14-0x1C unmapped.
REQ-016 SHALL drive req_ready = ~resp_valid | resp_ready (combinational); at most one outstanding response.
REQ-017 SHALL assert resp_valid the cycle after acceptance and hold resp_valid, resp_rdata, resp_err stable until resp_ready.
REQ-018 SHALL apply writes at the acceptance edge, per byte where req_wstrb bit is 1; wstrb = 0 is a no-op write with normal response.
REQ-019 SHALL, on unmapped access, ignore write data, return resp_rdata = 0, resp_err = 1.
REQ-020 SHALL keep a prescaler counter 0..PRESCALE-1; while enable = 1 it increments each cycle and wraps to 0, producing a one-cycle tick on the wrap; PRESCALE = 1 ticks every cycle.
REQ-021 SHALL freeze the prescaler (value held) while enable = 0; writing enable does not clear it.
REQ-022 SHALL increment mtime by 1 (64-bit, wraps 2^64-1 -> 0) on each tick.
REQ-023 SHALL give a bus write to either mtime word priority over a same-cycle tick: written bytes take the written value, and the unwritten mtime bits hold (no increment that cycle).
REQ-024 SHALL, on a read of 0x00, return mtime[31:0] and capture mtime[63:32] into a shadow register in the same edge.
REQ-025 SHALL, on a read of 0x04, return the shadow register (not live mtime[63:32]), giving a tear-free lo-then-hi read.
REQ-026 SHALL return read data sampled from register values before any same-edge update (read-old).
REQ-027 SHALL register irq_mtimecmp = (mtime >= mtimecmp), unsigned 64-bit, evaluated on post-update values; level stays high until mtimecmp raised or mtime rewritten below it.
REQ-028 SHALL keep irq_mtimecmp computed regardless of enable.

Reset
REQ-029 SHALL, on reset, set mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, enable = 1, prescaler = 0, shadow = 0.
REQ-030 SHALL, on reset, drive resp_valid = 0, resp_rdata = 0, resp_err = 0, irq_mtimecmp = 0.
REQ-031 SHALL let reset override any in-flight request or pending response (response discarded, no write applied that cycle).

Verification
REQ-032 PRESCALE=4, reset released, no bus traffic for 40 cycles -> read 0x00 returns 10 (±1 per documented phase), resp_err = 0.
REQ-033 Write mtimecmp_hi = 0, mtimecmp_lo = 20, PRESCALE=1 -> irq_mtimecmp rises the cycle after mtime reaches 20 and stays 1; write mtimecmp_lo = 0xFFFF_FFFF -> irq falls next cycle.
REQ-034 Write mtime = 0x0000_0000_FFFF_FFFF, read 0x00 when lo = 0xFFFF_FFFF, then read 0x04 after rollover -> hi returns 0 (shadow), not 1.
REQ-035 Write mtime_lo with wstrb = 4'b0001, data 0xAA on a tick cycle -> mtime[7:0] = 0xAA, other bits unchanged, no increment.
REQ-036 Write ctrl = 0 -> mtime constant over 100 cycles; write ctrl = 1 -> counting resumes from held prescaler phase.
REQ-037 Read 0x18 with resp_ready held 0 for 5 cycles -> resp_valid, rdata = 0, resp_err = 1 held stable, req_ready = 0 throughout; a subsequent request is accepted the same cycle resp_ready goes 1.
